tree_grng_pipe: RTL and testbench

TREE_GRNG_PIPE -- requirements
Module: tree_grng_pipe

---
 rtl/tree_grng_pkg.sv | 39 +++
 rtl/tree_grng_stage.sv | 22 ++
 rtl/tree_grng_pipe.sv | 72 +++++++
 tb/tb_tree_grng_pipe.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tree_grng_pkg.sv
// Shared constants and elaboration-time helpers for the tree Gaussian generator.
package tree_grng_pkg;

    localparam logic [63:0] XS_RESET = 64'h9E3779B97F4A7C15;
    localparam int XS_A = 13;
    localparam int XS_B = 7;
    localparam int XS_C = 17;

    // Selector width of stage s; the last stage is capped one lower so its table stays small.
    function automatic int n_sel(input int s, input int out_w, input int sel_max);
        int n;
        if (s == 0)
            n = 0;
        else if (s == out_w - 1) begin
            n = (out_w - 1 < sel_max - 1) ? out_w - 1 : sel_max - 1;
            if (n < 1) n = 1;
        end else
            n = (s < sel_max) ? s : sel_max;
        return n;
    endfunction

    // Bit 0 feeds stage 0; later stages take disjoint fields packed upward from bit 1.
    function automatic int bit_offset(input int s, input int out_w, input int sel_max);
        int off;
        off = 1;
        for (int k = 1; k < s; k++)
            off += 1 << (n_sel(k, out_w, sel_max) - 1);
        return off;
    endfunction

    function automatic logic [63:0] xs_step(input logic [63:0] x);
        logic [63:0] t;
        t = x ^ (x << XS_A);
        t = t ^ (t >> XS_B);
        t = t ^ (t << XS_C);
        return t;
    endfunction

endpackage

// File: rtl/tree_grng_stage.sv
// One decision stage: mirror-complement table built from P, indexed by the recent bits.
module tree_grng_stage #(
    parameter int N = 1
) (
    input  logic [2**(N-1)-1:0] p,
    input  logic [N-1:0]        sel,
    output logic                b
);

    localparam int HALF = 2**(N-1);

    logic [2*HALF-1:0] tbl;

    // Upper half mirrors the lower half inverted, keeping the tree symmetric.
    for (genvar i = 0; i < HALF; i++) begin : g_tbl
        assign tbl[i]            = p[i];
        assign tbl[2*HALF-1-i]   = ~p[i];
    end

    assign b = tbl[sel];

endmodule

// File: rtl/tree_grng_pipe.sv
// Pipelined tree GRNG: one output bit resolved per stage from a shared xorshift64 state.
module tree_grng_pipe
    import tree_grng_pkg::*;
#(
    parameter int OUT_W   = 8,
    parameter int SEL_MAX = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             seed_load,
    input  logic [63:0]      seed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data
);

    logic [63:0]                  x;
    logic [OUT_W-1:0]             vld_pipe;
    logic [OUT_W-1:0][OUT_W-1:0]  dat;
    logic [OUT_W-1:0][OUT_W-1:0]  dat_nxt;
    logic [OUT_W-1:0]             bnew;
    logic                         stall;

    if (bit_offset(OUT_W, OUT_W, SEL_MAX) > 64) begin : g_chk
        $error("tree_grng_pipe: stage fields need more than 64 state bits");
    end

    assign bnew[0] = x[0];

    for (genvar s = 1; s < OUT_W; s++) begin : g_stg
        localparam int N   = n_sel(s, OUT_W, SEL_MAX);
        localparam int OFF = bit_offset(s, OUT_W, SEL_MAX);
        tree_grng_stage #(.N(N)) u_stg (
            .p   (x[OFF +: 2**(N-1)]),
            .sel (dat[s-1][OUT_W-s +: N]),
            .b   (bnew[s])
        );
    end

    // Stage s holds bits b[OUT_W-1 : OUT_W-1-s]; lower bits stay zero until resolved.
    always_comb begin
        dat_nxt = '0;
        dat_nxt[0][OUT_W-1] = bnew[0];
        for (int s = 1; s < OUT_W; s++) begin
            dat_nxt[s] = dat[s-1];
            dat_nxt[s][OUT_W-1-s] = bnew[s];
        end
    end

    assign stall = out_valid && !out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x        <= XS_RESET;
            vld_pipe <= '0;
            dat      <= '0;
        end else if (seed_load) begin
            x        <= (seed == 64'd0) ? XS_RESET : seed;
            vld_pipe <= '0;
        end else if (!stall) begin
            x        <= xs_step(x);
            vld_pipe <= {vld_pipe[OUT_W-2:0], en};
            dat      <= dat_nxt;
        end
    end

    assign out_valid = vld_pipe[OUT_W-1];
    // Offset binary to two's complement; forced to zero when nothing is presented.
    assign out_data  = out_valid ? {~dat[OUT_W-1][OUT_W-1], dat[OUT_W-1][OUT_W-2:0]} : '0;

endmodule

// File: tb/tb_tree_grng_pipe.sv
// Randomized and directed checks of tree_grng_pipe against a step-indexed reference model.
module tb_tree_grng_pipe;

    localparam int W   = 8;
    localparam int SM  = 5;
    localparam int WB  = 10;
    localparam int SMB = 4;
    localparam logic [63:0] XS0 = 64'h9E3779B97F4A7C15;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic en = 1'b0, seed_load = 1'b0, out_ready = 1'b0, out_valid;
    logic [63:0] seed = 64'd0;
    logic [W-1:0] out_data;
    logic en_b = 1'b0, seed_load_b = 1'b0, out_ready_b = 1'b1, out_valid_b;
    logic [63:0] seed_b = 64'd0;
    logic [WB-1:0] out_data_b;

    always #5 clk = ~clk;

    tree_grng_pipe #(.OUT_W(W), .SEL_MAX(SM)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .seed_load(seed_load), .seed(seed),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data));

    tree_grng_pipe #(.OUT_W(WB), .SEL_MAX(SMB)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en_b), .seed_load(seed_load_b), .seed(seed_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b), .out_data(out_data_b));

    int n_cmp = 0, n_bad = 0;
    logic [63:0] xh[$];   // X value at every pipeline step since last seed
    int q[$];             // step index at which each outstanding sample was accepted
    logic [63:0] xhb[$];
    int jb, hs_cnt;
    bit b_on = 0, st_on = 0, unk_a = 0, unk_b = 0;
    int hist_a[256];
    int hist_b[1024];
    longint sum_a, sum_b;
    int na, nb;

    function automatic logic [63:0] xstep(input logic [63:0] v);
        logic [63:0] t;
        t = v ^ (v << 13);
        t = t ^ (t >> 7);
        t = t ^ (t << 17);
        return t;
    endfunction

    function automatic int nsel(input int s, input int w, input int smax);
        int n;
        if (s == 0) return 0;
        if (s == w - 1) begin
            n = (w - 1 < smax - 1) ? w - 1 : smax - 1;
            return (n < 1) ? 1 : n;
        end
        return (s < smax) ? s : smax;
    endfunction

    // Sample whose stage s sees X value xv[s]; returned in out_data form.
    function automatic logic [15:0] gen(input int w, input int smax, input logic [63:0] xv[16]);
        int b, off, n, half, sel;
        bit bt;
        b = int'(xv[0][0]) << (w - 1);
        off = 1;
        for (int s = 1; s < w; s++) begin
            n = nsel(s, w, smax);
            half = 1 << (n - 1);
            sel = (b >> (w - s)) & ((1 << n) - 1);
            if (sel < half) bt = xv[s][off + sel];
            else            bt = ~xv[s][off + 2*half - 1 - sel];
            b = b | (int'(bt) << (w - 1 - s));
            off += half;
        end
        return 16'(b ^ (1 << (w - 1)));
    endfunction

    function automatic bit exp_valid();
        return q.size() > 0 && q[0] + W <= xh.size() - 1;
    endfunction

    function automatic logic [15:0] exp_a();
        logic [63:0] xv[16];
        for (int i = 0; i < 16; i++) begin
            xv[i] = 64'd0;
            if (i < W) xv[i] = xh[q[0] + i];
        end
        return gen(W, SM, xv);
    endfunction

    function automatic logic [15:0] exp_b();
        logic [63:0] xv[16];
        for (int i = 0; i < 16; i++) begin
            xv[i] = 64'd0;
            if (i < WB) xv[i] = xhb[jb + i];
        end
        return gen(WB, SMB, xv);
    endfunction

    task automatic model_seed(input logic [63:0] v);
        xh.delete();
        q.delete();
        xh.push_back(v);
        hs_cnt = 0;
    endtask

    // Drive one clock of inputs, advance the model, check outputs on the falling edge.
    task automatic tick(input bit e, input bit r, input bit sl, input logic [63:0] sd);
        bit v, vb;
        logic [15:0] ex, got;
        en = e; out_ready = r; seed_load = sl; seed = sd;
        v = exp_valid();
        if (st_on && v && r && !sl) begin
            if ($isunknown(out_data)) unk_a = 1;
            hist_a[int'(out_data ^ 8'h80)]++;
            sum_a += longint'($signed(out_data));
            na++;
        end
        if (sl) model_seed((sd == 64'd0) ? XS0 : sd);
        else if (!(v && !r)) begin
            if (v) begin void'(q.pop_front()); hs_cnt++; end
            if (e) q.push_back(xh.size() - 1);
            xh.push_back(xstep(xh[$]));
        end
        if (b_on) xhb.push_back(xstep(xhb[$]));
        @(posedge clk);
        @(negedge clk);
        v = exp_valid();
        n_cmp++;
        if (out_valid !== v) begin
            n_bad++;
            $display("FAIL valid: got %b want %b", out_valid, v);
        end else if (v) begin
            ex = exp_a();
            got = 16'(out_data);
            n_cmp++;
            if (got !== ex) begin
                n_bad++;
                $display("FAIL data: got %h want %h", got, ex);
            end
        end
        if (b_on) begin
            vb = (xhb.size() - 1 >= jb + WB);
            n_cmp++;
            if (out_valid_b !== vb) begin
                n_bad++;
                $display("FAIL valid_b: got %b want %b", out_valid_b, vb);
            end else if (vb) begin
                ex = exp_b();
                got = 16'(out_data_b);
                n_cmp++;
                if (got !== ex) begin
                    n_bad++;
                    $display("FAIL data_b: got %h want %h", got, ex);
                end
                if ($isunknown(out_data_b)) unk_b = 1;
                hist_b[int'(out_data_b ^ 10'h200)]++;
                sum_b += longint'($signed(out_data_b));
                nb++;
                jb++;
            end
        end
    endtask

    task automatic test_reset();
        int first;
        #1 rst_n = 1'b0;
        en = 1'b1; out_ready = 1'b1;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            n_cmp++;
            if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", out_valid); end
            n_cmp++;
            if (out_data !== '0) begin n_bad++; $display("FAIL reset_data: got %h want 00", out_data); end
        end
        model_seed(XS0);
        rst_n = 1'b1;
        first = 0;
        for (int i = 1; i <= 20 && first == 0; i++) begin
            tick(1'b1, 1'b1, 1'b0, 64'd0);
            if (out_valid === 1'b1) first = i;
        end
        n_cmp++;
        if (first != 8) begin n_bad++; $display("FAIL reset_latency: got %0d want 8", first); end
    endtask

    task automatic test_golden();
        int budget;
        budget = 0;
        while (hs_cnt < 1000 && budget < 1200) begin
            tick(1'b1, 1'b1, 1'b0, 64'd0);
            budget++;
        end
        n_cmp++;
        if (hs_cnt < 1000) begin n_bad++; $display("FAIL golden_count: got %0d want 1000", hs_cnt); end
    endtask

    task automatic test_stall();
        logic [15:0] held;
        n_cmp++;
        if (out_valid !== 1'b1) begin n_bad++; $display("FAIL stall_pre: got %b want 1", out_valid); end
        held = exp_a();
        repeat (5) begin
            tick(1'b1, 1'b0, 1'b0, 64'd0);
            n_cmp++;
            if (16'(out_data) !== held) begin n_bad++; $display("FAIL stall_hold: got %h want %h", out_data, held); end
        end
        repeat (20) tick(1'b1, 1'b1, 1'b0, 64'd0);
    endtask

    task automatic test_seed0();
        int first;
        tick(1'b1, 1'b1, 1'b1, 64'd0);
        n_cmp++;
        if (out_valid !== 1'b0) begin n_bad++; $display("FAIL seed_valid: got %b want 0", out_valid); end
        first = 0;
        for (int i = 1; i <= 30; i++) begin
            tick(1'b1, 1'b1, 1'b0, 64'd0);
            if (out_valid === 1'b1 && first == 0) first = i;
        end
        n_cmp++;
        if (first != 8) begin n_bad++; $display("FAIL seed_latency: got %0d want 8", first); end
    endtask

    task automatic test_en_toggle();
        bit ov;
        repeat (12) tick(1'b0, 1'b1, 1'b0, 64'd0);
        for (int j = 0; j < 12; j++) begin
            tick(j < 4 && (j % 2) == 0, 1'b1, 1'b0, 64'd0);
            ov = (j == 7 || j == 9);
            n_cmp++;
            if (out_valid !== ov) begin n_bad++; $display("FAIL toggle[%0d]: got %b want %b", j, out_valid, ov); end
        end
    endtask

    task automatic test_async_reset();
        repeat (12) tick(1'b1, 1'b1, 1'b0, 64'd0);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0) begin n_bad++; $display("FAIL async_valid: got %b want 0", out_valid); end
        n_cmp++;
        if (out_data !== '0) begin n_bad++; $display("FAIL async_data: got %h want 00", out_data); end
        @(negedge clk);
        model_seed(XS0);
        rst_n = 1'b1;
        repeat (20) tick(1'b1, 1'b1, 1'b0, 64'd0);
    endtask

    task automatic test_random();
        bit e, r, sl;
        logic [63:0] sd;
        for (int i = 0; i < 2000; i++) begin
            e  = ($urandom_range(0, 3) != 0);
            r  = ($urandom_range(0, 2) != 0);
            sl = ($urandom_range(0, 99) == 0);
            sd = ($urandom_range(0, 3) == 0) ? 64'd0 : {$urandom, $urandom};
            tick(e, r, sl, sd);
        end
    endtask

    task automatic test_stats();
        int budget, maxd, d;
        seed_load_b = 1'b1; seed_b = 64'd0; en_b = 1'b0;
        tick(1'b1, 1'b1, 1'b0, 64'd0);
        seed_load_b = 1'b0;
        n_cmp++;
        if (out_valid_b !== 1'b0) begin n_bad++; $display("FAIL seed_b_valid: got %b want 0", out_valid_b); end
        xhb.delete(); xhb.push_back(XS0); jb = 0;
        en_b = 1'b1; b_on = 1; st_on = 1;
        na = 0; nb = 0; sum_a = 0; sum_b = 0;
        budget = 0;
        while (na < 65536 && budget < 70000) begin
            tick(1'b1, 1'b1, 1'b0, 64'd0);
            budget++;
        end
        st_on = 0; b_on = 0; en_b = 1'b0;
        n_cmp++;
        if (na < 65536) begin n_bad++; $display("FAIL stats_count: got %0d want 65536", na); end
        n_cmp++;
        if (unk_a || unk_b) begin n_bad++; $display("FAIL stats_unknown: got %b%b want 00", unk_a, unk_b); end
        // Mean window [-2^(W-8), 2^(W-8)-1]; reduces to [-1, 0] for the 8-bit build.
        n_cmp++;
        if (sum_a < -longint'(na) || sum_a > 0) begin
            n_bad++; $display("FAIL mean_a: got sum %0d over %0d want within [-1,0]", sum_a, na);
        end
        n_cmp++;
        if (sum_b < -4 * longint'(nb) || sum_b > 3 * longint'(nb)) begin
            n_bad++; $display("FAIL mean_b: got sum %0d over %0d want within [-4,3]", sum_b, nb);
        end
        maxd = 0;
        for (int b = 0; b < 256; b++) begin
            d = hist_a[b] - hist_a[255 - b];
            if (d < 0) d = -d;
            if (d > maxd) maxd = d;
        end
        n_cmp++;
        if (maxd * 50 > na) begin n_bad++; $display("FAIL sym_a: got maxdiff %0d want <= %0d", maxd, na / 50); end
        maxd = 0;
        for (int b = 0; b < 1024; b++) begin
            d = hist_b[b] - hist_b[1023 - b];
            if (d < 0) d = -d;
            if (d > maxd) maxd = d;
        end
        n_cmp++;
        if (maxd * 50 > nb) begin n_bad++; $display("FAIL sym_b: got maxdiff %0d want <= %0d", maxd, nb / 50); end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_golden();
        test_stall();
        test_seed0();
        test_en_toggle();
        test_async_reset();
        test_random();
        test_stats();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
